// File: rtl/fu_req_arbiter_pkg.sv
// Shared definitions for the function-unit request arbiter: FS opcodes,
// FSM state encoding and flag bit positions.
package fu_req_arbiter_pkg;

  // Logic group
  localparam logic [3:0] FS_MOVA = 4'b0000;
  localparam logic [3:0] FS_AND  = 4'b0001;
  localparam logic [3:0] FS_OR   = 4'b0010;
  localparam logic [3:0] FS_XOR  = 4'b0011;
  localparam logic [3:0] FS_NOTA = 4'b0100;
  localparam logic [3:0] FS_MOVB = 4'b0101;
  localparam logic [3:0] FS_NAND = 4'b0110;
  localparam logic [3:0] FS_NOR  = 4'b0111;
  // Arithmetic group
  localparam logic [3:0] FS_ADD  = 4'b1000;
  localparam logic [3:0] FS_SUB  = 4'b1001;
  localparam logic [3:0] FS_INCA = 4'b1010;
  localparam logic [3:0] FS_DECA = 4'b1011;
  localparam logic [3:0] FS_NEGB = 4'b1100;
  localparam logic [3:0] FS_LAST_LEGAL = FS_NEGB;

  // Flag vector is {V,C,N,Z}
  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Codes above the arithmetic group have no FU meaning.
  function automatic logic fs_illegal(input logic [3:0] fs);
    return fs > FS_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/fu_req_arbiter_if.sv
// Requester-side bus of the FU arbiter: packed per-requester operands and
// request lines out, shared response and one-hot completion back.
interface fu_req_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int W     = 8
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] req_opa;
  logic [N_REQ*W-1:0] req_opb;
  logic [N_REQ*4-1:0] req_fs;
  logic [N_REQ-1:0]   done;
  logic [W-1:0]       rsp_result;
  logic [3:0]         rsp_flags;
  logic               rsp_err;

  modport master (
    output req, req_opa, req_opb, req_fs,
    input  done, rsp_result, rsp_flags, rsp_err
  );

  modport slave (
    input  req, req_opa, req_opb, req_fs,
    output done, rsp_result, rsp_flags, rsp_err
  );
endinterface

// File: rtl/fu_req_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo N_REQ. Returns both one-hot and binary winner.
module fu_req_arbiter_rr #(
  parameter int N_REQ = 2,
  parameter int PW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    gnt_id
);

  // Scan from ptr, first hit wins.
  always_comb begin
    // NOTE: defaults first so every path assigns gnt/gnt_id and no latch is inferred.
    gnt    = '0;
    gnt_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx] && (gnt == '0)) begin
        gnt[idx] = 1'b1;
        gnt_id   = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/fu_req_arbiter.sv
// Shares one external combinational FU between N_REQ requesters.
// IDLE grants round-robin and latches the winner's operands onto fu_*,
// EXEC captures the FU response, DONE pulses done[winner] and advances.
module fu_req_arbiter
  import fu_req_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fu_req_arbiter_if.slave  rq,
  output logic             busy,
  output logic [W-1:0]     fu_opa,
  output logic [W-1:0]     fu_opb,
  output logic [3:0]       fu_fs,
  input  logic [W-1:0]     fu_result,
  input  logic [3:0]       fu_flags,
  output logic [CNT_W-1:0] op_count
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win_id;
  logic [N_REQ-1:0] win_oh;
  logic [N_REQ-1:0] gnt;
  logic [PW-1:0]    gnt_id;
  logic [N_REQ-1:0] done_q;
  logic [W-1:0]     rsp_result_q;
  logic [3:0]       rsp_flags_q;
  logic             rsp_err_q;

  fu_req_arbiter_rr #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr (
    .req    (rq.req),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign rq.done       = done_q;
  assign rq.rsp_result = rsp_result_q;
  assign rq.rsp_flags  = rsp_flags_q;
  assign rq.rsp_err    = rsp_err_q;

  // Control FSM with registered outputs, operand latch, response and counter.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      win_id       <= '0;
      win_oh       <= '0;
      done_q       <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
      busy         <= 1'b0;
      fu_opa       <= '0;
      fu_opb       <= '0;
      fu_fs        <= 4'b0000;
      op_count     <= '0;
    end else begin
      done_q <= '0;
      case (state)
        ST_IDLE: begin
          if (|rq.req) begin
            fu_opa <= rq.req_opa[int'(gnt_id)*W +: W];
            fu_opb <= rq.req_opb[int'(gnt_id)*W +: W];
            fu_fs  <= rq.req_fs[int'(gnt_id)*4 +: 4];
            win_id <= gnt_id;
            win_oh <= gnt;
            busy   <= 1'b1;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (fs_illegal(fu_fs)) begin
            rsp_err_q    <= 1'b1;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
          end else begin
            rsp_err_q    <= 1'b0;
            rsp_result_q <= fu_result;
            rsp_flags_q  <= fu_flags;
          end
          done_q <= win_oh;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          ptr      <= (int'(win_id) == N_REQ - 1) ? '0 : win_id + 1'b1;
          op_count <= op_count + 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fu_req_arbiter.sv
// Bench for fu_req_arbiter: real FU behind fu_*, a transaction-level model
// compared every cycle, and directed scenarios with literal expectations.
module tb_fu_req_arbiter;
  import fu_req_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int CW = 6;   // small counter so the wrap is reachable quickly

  logic          clk = 1'b0;
  logic          rst_n;
  logic          busy;
  logic [W-1:0]  fu_opa, fu_opb, fu_result;
  logic [3:0]    fu_fs, fu_flags;
  logic [CW-1:0] op_count;

  int total = 0;
  int bad   = 0;

  fu_req_arbiter_if #(.N_REQ(N), .W(W)) bus ();

  fu_req_arbiter #(.N_REQ(N), .W(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rq        (bus),
    .busy      (busy),
    .fu_opa    (fu_opa),
    .fu_opb    (fu_opb),
    .fu_fs     (fu_fs),
    .fu_result (fu_result),
    .fu_flags  (fu_flags),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  // ---------------- FU: adder-based datapath ----------------
  logic [7:0] fx, fy;
  logic       fcin, farith;
  logic [8:0] fsum;
  always_comb begin
    fx = fu_opa; fy = '0; fcin = 1'b0; farith = 1'b0;
    fsum = '0; fu_result = '0; fu_flags = '0;
    case (fu_fs)
      FS_MOVA: fu_result = fu_opa;
      FS_AND:  fu_result = fu_opa & fu_opb;
      FS_OR:   fu_result = fu_opa | fu_opb;
      FS_XOR:  fu_result = fu_opa ^ fu_opb;
      FS_NOTA: fu_result = ~fu_opa;
      FS_MOVB: fu_result = fu_opb;
      FS_NAND: fu_result = ~(fu_opa & fu_opb);
      FS_NOR:  fu_result = ~(fu_opa | fu_opb);
      FS_ADD:  begin farith = 1'b1; fy = fu_opb; end
      FS_SUB:  begin farith = 1'b1; fy = ~fu_opb; fcin = 1'b1; end
      FS_INCA: begin farith = 1'b1; fcin = 1'b1; end
      FS_DECA: begin farith = 1'b1; fy = 8'hFF; end
      FS_NEGB: begin farith = 1'b1; fx = '0; fy = ~fu_opb; fcin = 1'b1; end
      default: fu_result = 8'hA5;   // junk the arbiter must suppress
    endcase
    if (farith) begin
      fsum = {1'b0, fx} + {1'b0, fy} + 9'(fcin);
      fu_result = fsum[7:0];
      fu_flags[FLAG_C] = fsum[8];
      fu_flags[FLAG_V] = (fx[7] == fy[7]) && (fu_result[7] != fx[7]);
    end
    if (fs_illegal(fu_fs)) fu_flags = 4'hF;
    else begin
      fu_flags[FLAG_N] = fu_result[7];
      fu_flags[FLAG_Z] = (fu_result == 8'h00);
    end
  end

  // ---------------- reference model ----------------
  // Integer-arithmetic ALU: returns {V,C,N,Z,result}; illegal codes give 0.
  function automatic logic [11:0] ref_alu(input logic [7:0] a, b, input logic [3:0] fs);
    int ua, ub, sa, sb, u, s;
    logic [7:0] r;
    logic v, c;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    u = 0; s = 0; r = '0; v = 1'b0; c = 1'b0;
    if (fs > 4'd12) return 12'h000;
    case (fs)
      4'd0: r = a;
      4'd1: r = a & b;
      4'd2: r = a | b;
      4'd3: r = a ^ b;
      4'd4: r = ~a;
      4'd5: r = b;
      4'd6: r = ~(a & b);
      4'd7: r = ~(a | b);
      4'd8:  begin u = ua + ub;       s = sa + sb; end
      4'd9:  begin u = 256 + ua - ub; s = sa - sb; end
      4'd10: begin u = ua + 1;        s = sa + 1;  end
      4'd11: begin u = ua + 255;      s = sa - 1;  end
      default: begin u = 256 - ub;    s = -sb;     end
    endcase
    if (fs >= 4'd8) begin
      r = 8'(u);
      c = (u > 255);
      v = (s > 127) || (s < -128);
    end
    return {v, c, r[7], (r == 8'h00), r};
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // Model state: ops advance one step per cycle after a grant.
  int            m_step;      // 0 free, 1 granted, 2 completing
  int            m_ptr, m_win, m_pick;
  logic [W-1:0]  m_opa, m_opb, m_res;
  logic [3:0]    m_fs, m_flags;
  logic          m_err;
  logic [N-1:0]  m_done;
  logic [CW-1:0] m_cnt;

  always_comb m_pick = pick(bus.req, m_ptr);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_step <= 0; m_ptr <= 0; m_win <= 0;
      m_opa <= '0; m_opb <= '0; m_fs <= '0;
      m_res <= '0; m_flags <= '0; m_err <= 1'b0;
      m_done <= '0; m_cnt <= '0;
    end else if (m_step == 0) begin
      m_done <= '0;
      if (|bus.req) begin
        m_win  <= m_pick;
        m_opa  <= bus.req_opa[m_pick*W +: W];
        m_opb  <= bus.req_opb[m_pick*W +: W];
        m_fs   <= bus.req_fs[m_pick*4 +: 4];
        m_step <= 1;
      end
    end else if (m_step == 1) begin
      {m_flags, m_res} <= ref_alu(m_opa, m_opb, m_fs);
      m_err  <= (m_fs > 4'd12);
      m_done <= N'(1) << m_win;
      m_step <= 2;
    end else begin
      m_done <= '0;
      m_ptr  <= (m_win + 1) % N;
      m_cnt  <= m_cnt + 1'b1;
      m_step <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("done",       32'(bus.done),       32'(m_done));
    check("busy",       32'(busy),           32'(m_step != 0));
    check("op_count",   32'(op_count),       32'(m_cnt));
    check("fu_opa",     32'(fu_opa),         32'(m_opa));
    check("fu_opb",     32'(fu_opb),         32'(m_opb));
    check("fu_fs",      32'(fu_fs),          32'(m_fs));
    check("rsp_result", 32'(bus.rsp_result), 32'(m_res));
    check("rsp_flags",  32'(bus.rsp_flags),  32'(m_flags));
    check("rsp_err",    32'(bus.rsp_err),    32'(m_err));
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_op(input int i, input logic [7:0] a, b, input logic [3:0] fs);
    bus.req_opa[i*W +: W] = a;
    bus.req_opb[i*W +: W] = b;
    bus.req_fs[i*4 +: 4]  = fs;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int idx, input int budget, output int n);
    n = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      n++;
      if (bus.done[idx]) return;
    end
    total++; bad++;
    $display("FAIL wait_done[%0d]: no done within %0d cycles, required a pulse", idx, budget);
  endtask

  task automatic wait_any(input int budget, output int who);
    who = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (|bus.done) begin
        who = bus.done[1] ? 1 : 0;
        return;
      end
    end
    total++; bad++;
    $display("FAIL wait_any: no done within %0d cycles, required a pulse", budget);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n, who;
    bus.req = '0; bus.req_opa = '0; bus.req_opb = '0; bus.req_fs = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy), 0);
    check("rst_count", 32'(op_count), 0);
    check("rst_fu_fs", 32'(fu_fs), 0);
    rst_n = 1'b1;

    // Reset during EXEC aborts the op without a done pulse.
    set_op(0, 8'h12, 8'h34, FS_ADD);
    bus.req[0] = 1'b1;
    @(negedge clk);
    check("abort_busy_exec", 32'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(bus.done), 0);
    bus.req = '0;
    @(negedge clk);
    check("abort_done2", 32'(bus.done), 0);
    check("abort_count", 32'(op_count), 0);
    rst_n = 1'b1;

    // Single request; operand change after grant must be ignored.
    @(negedge clk);
    set_op(0, 8'h7F, 8'h01, FS_ADD);
    bus.req[0] = 1'b1;
    @(negedge clk);
    bus.req_opa[7:0] = 8'hFF;
    wait_done(0, 8, n);
    check("single_latency", 32'(n), 1);
    check("single_result",  32'(bus.rsp_result), 32'h80);
    check("single_flags",   32'(bus.rsp_flags), 32'b1010);
    check("single_err",     32'(bus.rsp_err), 0);
    bus.req[0] = 1'b0;
    @(negedge clk);
    check("single_count", 32'(op_count), 1);

    // Two requesters held from reset: grants alternate 0,1,0,1.
    do_reset();
    set_op(0, 8'hF0, 8'h3C, FS_XOR);
    set_op(1, 8'h55, 8'h55, FS_SUB);
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_any(8, who);
      check("rr_grant", 32'(who), 32'(k % 2));
      if (who == 1) begin
        check("rr_sub_result", 32'(bus.rsp_result), 32'h00);
        check("rr_sub_flags",  32'(bus.rsp_flags), 32'b0101);
      end else begin
        check("rr_xor_result", 32'(bus.rsp_result), 32'hCC);
        check("rr_xor_flags",  32'(bus.rsp_flags), 32'b0010);
      end
    end
    bus.req = '0;

    // Illegal FS on requester 1, req dropped mid-op; then a legal op.
    @(negedge clk);
    set_op(1, 8'h12, 8'h34, 4'b1110);
    bus.req[1] = 1'b1;
    @(negedge clk);
    bus.req[1] = 1'b0;
    wait_done(1, 8, n);
    check("ill_err",    32'(bus.rsp_err), 1);
    check("ill_result", 32'(bus.rsp_result), 0);
    check("ill_flags",  32'(bus.rsp_flags), 0);
    set_op(1, 8'h7F, 8'h00, FS_INCA);
    bus.req[1] = 1'b1;
    wait_done(1, 8, n);
    check("legal_err",    32'(bus.rsp_err), 0);
    check("legal_result", 32'(bus.rsp_result), 32'h80);
    check("legal_flags",  32'(bus.rsp_flags), 32'b1010);
    bus.req[1] = 1'b0;
    @(negedge clk);
    check("after_ill_count", 32'(op_count), 6);

    // req held through done: the same op is issued again.
    do_reset();
    set_op(0, 8'hF0, 8'h3C, FS_AND);
    bus.req[0] = 1'b1;
    wait_done(0, 8, n);
    check("held_result1", 32'(bus.rsp_result), 32'h30);
    wait_done(0, 8, n);
    check("held_gap",     32'(n), 3);
    check("held_result2", 32'(bus.rsp_result), 32'h30);
    bus.req[0] = 1'b0;
    @(negedge clk);
    check("held_count", 32'(op_count), 2);

    // Sweep every FS code across both requesters until the counter wraps.
    do_reset();
    for (int k = 0; k < 64; k++) begin
      set_op(k % 2, 8'(k * 37 + 11), 8'(k * 91 + 3), 4'(k));
      bus.req[k % 2] = 1'b1;
      wait_done(k % 2, 8, n);
      bus.req[k % 2] = 1'b0;
      @(negedge clk);
      if (k == 62) check("wrap_pre",  32'(op_count), 63);
      if (k == 63) check("wrap_zero", 32'(op_count), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
